// File: rtl/simple_axi_lite_ram_if.sv
// AXI4-Lite bus bundle for a word-addressed slave; clock and reset travel separately.
interface simple_axi_lite_ram_if #(
    parameter int ADDR_WIDTH_BITS  = 3,
    parameter int DATA_WIDTH_BYTES = 4
);
    localparam int DATA_WIDTH_BITS = DATA_WIDTH_BYTES * 8;

    logic                        ARVALID;
    logic                        ARREADY;
    logic [ADDR_WIDTH_BITS-1:0]  ARADDR;
    logic [3:0]                  ARPROT;
    logic                        RVALID;
    logic                        RREADY;
    logic [DATA_WIDTH_BITS-1:0]  RDATA;
    logic [1:0]                  RRESP;
    logic                        AWVALID;
    logic                        AWREADY;
    logic [ADDR_WIDTH_BITS-1:0]  AWADDR;
    logic [3:0]                  AWPROT;
    logic                        WVALID;
    logic                        WREADY;
    logic [DATA_WIDTH_BITS-1:0]  WDATA;
    logic [DATA_WIDTH_BYTES-1:0] WSTRB;
    logic                        BVALID;
    logic                        BREADY;
    logic [1:0]                  BRESP;

    modport master (
        output ARVALID, ARADDR, ARPROT, RREADY,
        output AWVALID, AWADDR, AWPROT, WVALID, WDATA, WSTRB, BREADY,
        input  ARREADY, RVALID, RDATA, RRESP,
        input  AWREADY, WREADY, BVALID, BRESP
    );

    modport slave (
        input  ARVALID, ARADDR, ARPROT, RREADY,
        input  AWVALID, AWADDR, AWPROT, WVALID, WDATA, WSTRB, BREADY,
        output ARREADY, RVALID, RDATA, RRESP,
        output AWREADY, WREADY, BVALID, BRESP
    );
endinterface

// File: rtl/simple_axi_lite_ram.sv
// AXI4-Lite word RAM: independent read/write FSMs, one outstanding transaction each,
// byte-strobe writes, SLVERR for addresses beyond NUM_SLOTS.
module simple_axi_lite_ram #(
    parameter int NUM_SLOTS        = 5,
    parameter int DATA_WIDTH_BYTES = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    simple_axi_lite_ram_if.slave     s
);
    localparam int ADDR_WIDTH_BITS = $clog2(NUM_SLOTS);
    localparam int DATA_WIDTH_BITS = DATA_WIDTH_BYTES * 8;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [1:0] W_ADDR = 2'd0;
    localparam logic [1:0] W_DATA = 2'd1;
    localparam logic [1:0] W_RESP = 2'd2;
    localparam logic       R_ADDR = 1'b0;
    localparam logic       R_DATA = 1'b1;

    logic [DATA_WIDTH_BITS-1:0] mem_q [NUM_SLOTS];
    logic [DATA_WIDTH_BITS-1:0] mem_d [NUM_SLOTS];

    logic [1:0]                 w_state_q, w_state_d;
    logic [ADDR_WIDTH_BITS-1:0] waddr_q, waddr_d;
    logic                       awready_q, awready_d;
    logic                       wready_q, wready_d;
    logic                       bvalid_q, bvalid_d;
    logic [1:0]                 bresp_q, bresp_d;

    logic                       r_state_q, r_state_d;
    logic                       arready_q, arready_d;
    logic                       rvalid_q, rvalid_d;
    logic [DATA_WIDTH_BITS-1:0] rdata_q, rdata_d;
    logic [1:0]                 rresp_q, rresp_d;

    logic unused_prot;
    assign unused_prot = ^{s.ARPROT, s.AWPROT};

    always_comb begin
        mem_d     = mem_q;
        w_state_d = w_state_q;
        waddr_d   = waddr_q;
        awready_d = awready_q;
        wready_d  = wready_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        case (w_state_q)
            W_ADDR: if (s.AWVALID && awready_q) begin
                waddr_d   = s.AWADDR;
                awready_d = 1'b0;
                wready_d  = 1'b1;
                w_state_d = W_DATA;
            end
            W_DATA: if (s.WVALID && wready_q) begin
                // Out-of-range addresses match no slot, so they write nothing.
                bresp_d = RESP_SLVERR;
                for (int i = 0; i < NUM_SLOTS; i++) begin
                    if (waddr_q == ADDR_WIDTH_BITS'(i)) begin
                        bresp_d = RESP_OKAY;
                        for (int k = 0; k < DATA_WIDTH_BYTES; k++)
                            if (s.WSTRB[k]) mem_d[i][8*k +: 8] = s.WDATA[8*k +: 8];
                    end
                end
                wready_d  = 1'b0;
                bvalid_d  = 1'b1;
                w_state_d = W_RESP;
            end
            W_RESP: if (s.BREADY && bvalid_q) begin
                bvalid_d  = 1'b0;
                awready_d = 1'b1;
                w_state_d = W_ADDR;
            end
            default: w_state_d = W_ADDR;
        endcase
    end

    // Reads sample mem_q, so a same-edge write commit is not visible yet.
    always_comb begin
        r_state_d = r_state_q;
        arready_d = arready_q;
        rvalid_d  = rvalid_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        case (r_state_q)
            R_ADDR: if (s.ARVALID && arready_q) begin
                rdata_d = '0;
                rresp_d = RESP_SLVERR;
                for (int i = 0; i < NUM_SLOTS; i++) begin
                    if (s.ARADDR == ADDR_WIDTH_BITS'(i)) begin
                        rdata_d = mem_q[i];
                        rresp_d = RESP_OKAY;
                    end
                end
                rvalid_d  = 1'b1;
                arready_d = 1'b0;
                r_state_d = R_DATA;
            end
            R_DATA: if (s.RREADY && rvalid_q) begin
                rvalid_d  = 1'b0;
                arready_d = 1'b1;
                r_state_d = R_ADDR;
            end
            default: r_state_d = R_ADDR;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_SLOTS; i++) mem_q[i] <= '0;
            w_state_q <= W_ADDR;
            waddr_q   <= '0;
            awready_q <= 1'b1;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
            r_state_q <= R_ADDR;
            arready_q <= 1'b1;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= RESP_OKAY;
        end else begin
            mem_q     <= mem_d;
            w_state_q <= w_state_d;
            waddr_q   <= waddr_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            r_state_q <= r_state_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
        end
    end

    assign s.AWREADY = awready_q;
    assign s.WREADY  = wready_q;
    assign s.BVALID  = bvalid_q;
    assign s.BRESP   = bresp_q;
    assign s.ARREADY = arready_q;
    assign s.RVALID  = rvalid_q;
    assign s.RDATA   = rdata_q;
    assign s.RRESP   = rresp_q;
endmodule

// File: tb/tb_simple_axi_lite_ram.sv
// Directed bench for simple_axi_lite_ram: handshake timing, strobes, range errors, reset abort.
module tb_simple_axi_lite_ram;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    simple_axi_lite_ram_if #(.ADDR_WIDTH_BITS(3), .DATA_WIDTH_BYTES(4)) bus ();

    simple_axi_lite_ram #(.NUM_SLOTS(5), .DATA_WIDTH_BYTES(4)) dut (
        .clk(clk),
        .rst(rst),
        .s  (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [2:0] a, input logic [31:0] d, input logic [3:0] st,
                            input logic [1:0] resp, input int bdelay);
        chk("wr_awready_idle", 32'(bus.AWREADY), 32'd1);
        bus.AWVALID = 1'b1; bus.AWADDR = a;
        tick();
        bus.AWVALID = 1'b0;
        chk("wr_awready_low", 32'(bus.AWREADY), 32'd0);
        chk("wr_wready_high", 32'(bus.WREADY), 32'd1);
        bus.WVALID = 1'b1; bus.WDATA = d; bus.WSTRB = st;
        tick();
        bus.WVALID = 1'b0;
        chk("wr_wready_low", 32'(bus.WREADY), 32'd0);
        chk("wr_bvalid", 32'(bus.BVALID), 32'd1);
        chk("wr_bresp", 32'(bus.BRESP), 32'(resp));
        repeat (bdelay) tick();
        chk("wr_bvalid_hold", 32'(bus.BVALID), 32'd1);
        chk("wr_bresp_hold", 32'(bus.BRESP), 32'(resp));
        bus.BREADY = 1'b1;
        tick();
        bus.BREADY = 1'b0;
        chk("wr_bvalid_done", 32'(bus.BVALID), 32'd0);
        chk("wr_awready_back", 32'(bus.AWREADY), 32'd1);
    endtask

    task automatic do_read(input logic [2:0] a, input logic [31:0] d, input logic [1:0] resp,
                           input int rdelay);
        chk("rd_arready_idle", 32'(bus.ARREADY), 32'd1);
        bus.ARVALID = 1'b1; bus.ARADDR = a;
        tick();
        bus.ARVALID = 1'b0;
        chk("rd_rvalid", 32'(bus.RVALID), 32'd1);
        chk("rd_arready_low", 32'(bus.ARREADY), 32'd0);
        chk("rd_rdata", bus.RDATA, d);
        chk("rd_rresp", 32'(bus.RRESP), 32'(resp));
        repeat (rdelay) tick();
        chk("rd_rvalid_hold", 32'(bus.RVALID), 32'd1);
        chk("rd_rdata_hold", bus.RDATA, d);
        chk("rd_rresp_hold", 32'(bus.RRESP), 32'(resp));
        bus.RREADY = 1'b1;
        tick();
        bus.RREADY = 1'b0;
        chk("rd_rvalid_done", 32'(bus.RVALID), 32'd0);
        chk("rd_arready_back", 32'(bus.ARREADY), 32'd1);
    endtask

    initial begin
        bus.ARVALID = 0; bus.ARADDR = 0; bus.ARPROT = 0; bus.RREADY = 0;
        bus.AWVALID = 0; bus.AWADDR = 0; bus.AWPROT = 0;
        bus.WVALID = 0; bus.WDATA = 0; bus.WSTRB = 0; bus.BREADY = 0;

        repeat (3) tick();
        rst = 1'b1;
        tick();
        chk("rst_arready", 32'(bus.ARREADY), 32'd1);
        chk("rst_awready", 32'(bus.AWREADY), 32'd1);
        chk("rst_rvalid", 32'(bus.RVALID), 32'd0);
        chk("rst_wready", 32'(bus.WREADY), 32'd0);
        chk("rst_bvalid", 32'(bus.BVALID), 32'd0);
        chk("rst_rdata", bus.RDATA, 32'h0);
        chk("rst_rresp", 32'(bus.RRESP), 32'd0);
        chk("rst_bresp", 32'(bus.BRESP), 32'd0);
        for (int i = 0; i < 5; i++) do_read(3'(i), 32'h0, 2'b00, 0);

        // Data before address must be ignored.
        bus.WVALID = 1'b1; bus.WDATA = 32'hFFFF_FFFF; bus.WSTRB = 4'hF;
        tick();
        bus.WVALID = 1'b0;
        chk("early_w_wready", 32'(bus.WREADY), 32'd0);
        chk("early_w_bvalid", 32'(bus.BVALID), 32'd0);

        do_write(3'd4, 32'h1122_3344, 4'b1101, 2'b00, 2);
        do_read(3'd4, 32'h1122_0044, 2'b00, 2);

        do_write(3'd0, 32'hAABB_CCDD, 4'b1111, 2'b00, 0);
        do_read(3'd0, 32'hAABB_CCDD, 2'b00, 0);
        do_read(3'd1, 32'h0000_0000, 2'b00, 0);

        do_write(3'd6, 32'hDEAD_BEEF, 4'b1111, 2'b10, 1);
        do_read(3'd6, 32'h0, 2'b10, 1);
        do_read(3'd7, 32'h0, 2'b10, 0);
        do_read(3'd4, 32'h1122_0044, 2'b00, 0);

        do_write(3'd1, 32'h5555_5555, 4'b0000, 2'b00, 0);
        do_read(3'd1, 32'h0, 2'b00, 0);

        // Read handshake on the same edge as a write commit sees old data.
        bus.AWVALID = 1'b1; bus.AWADDR = 3'd0;
        tick();
        bus.AWVALID = 1'b0;
        bus.WVALID = 1'b1; bus.WDATA = 32'h1234_5678; bus.WSTRB = 4'hF;
        bus.ARVALID = 1'b1; bus.ARADDR = 3'd0;
        tick();
        bus.WVALID = 1'b0; bus.ARVALID = 1'b0;
        chk("conc_rdata_old", bus.RDATA, 32'hAABB_CCDD);
        chk("conc_bvalid", 32'(bus.BVALID), 32'd1);
        chk("conc_rvalid", 32'(bus.RVALID), 32'd1);
        bus.BREADY = 1'b1; bus.RREADY = 1'b1;
        tick();
        bus.BREADY = 1'b0; bus.RREADY = 1'b0;
        chk("conc_bvalid_done", 32'(bus.BVALID), 32'd0);
        chk("conc_rvalid_done", 32'(bus.RVALID), 32'd0);
        do_read(3'd0, 32'h1234_5678, 2'b00, 0);

        // Reset while waiting for write data abandons the write.
        bus.AWVALID = 1'b1; bus.AWADDR = 3'd2;
        tick();
        bus.AWVALID = 1'b0;
        chk("abort_wready", 32'(bus.WREADY), 32'd1);
        rst = 1'b0;
        #1;
        chk("abort_rst_wready", 32'(bus.WREADY), 32'd0);
        chk("abort_rst_awready", 32'(bus.AWREADY), 32'd1);
        tick();
        rst = 1'b1;
        bus.WVALID = 1'b1; bus.WDATA = 32'hCAFE_F00D; bus.WSTRB = 4'hF;
        tick();
        bus.WVALID = 1'b0;
        chk("abort_late_w_wready", 32'(bus.WREADY), 32'd0);
        chk("abort_late_w_bvalid", 32'(bus.BVALID), 32'd0);
        do_read(3'd2, 32'h0, 2'b00, 0);
        do_read(3'd0, 32'h0, 2'b00, 0);
        do_read(3'd4, 32'h0, 2'b00, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
